mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Single-port byte-RAM controller and arbiter for the RISC-V core. Shares one 8-bit synchronous RAM port between the instruction-fetch stage (32-bit reads) and the MEM stage (byte/half/word reads and writes), serialising each access into little-endian byte beats. Provides the `if_busy_o` stall that gates the IF/ID register, and aborts fetches on `jump_i`.

## Interface
Parameters: none.

Ports (synchronous, active-high reset; reset polarity and synchronicity are fixed):
- `clk` in 1 — core clock.
- `rst` in 1 — synchronous, active-high reset.
- `jump_i` in 1 — branch/jump taken; aborts or blocks an IF fetch.
- `if_req_i` in 1 — fetch request, held until `if_done_o` or `jump_i`.
- `if_addr_i` in 32 — fetch byte address, stable while `if_req_i` is high.
- `if_busy_o` out 1 — `if_req_i & ~if_done_o`; combinational.
- `if_done_o` out 1 — one-cycle pulse; `if_inst_o` is valid in that cycle.
- `if_inst_o` out 32 — fetched word; holds its value until the next fetch completes.
- `mem_req_i` in 1 — MEM-stage request, held until `mem_done_o`.
- `mem_we_i` in 1 — 1 = write, 0 = read.
- `mem_len_i` in 2 — 00 byte, 01 half, 10 word; 11 is treated as word.
- `mem_addr_i` in 32 — byte address.
- `mem_wdata_i` in 32 — write data; low bytes are used.
- `mem_busy_o` out 1 — `mem_req_i & ~mem_done_o`.
- `mem_done_o` out 1 — one-cycle pulse.
- `mem_rdata_o` out 32 — read data, zero-extended. Sign extension is done by the MEM stage.
- `ram_din_i` in 8 — RAM read data. Corresponds to the address driven in the previous cycle.
- `ram_dout_o` out 8 — RAM write data.
- `ram_a_o` out 32 — RAM byte address.
- `ram_wr_o` out 1 — RAM write strobe.

## Operation
- FSM states: IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
- Arbitration happens in IDLE only:
  - `mem_req_i` wins over `if_req_i`.
  - An IF request is not accepted in a cycle where `jump_i` = 1.
  - The accepted address, length, we and wdata are latched at the accept edge (E0).
- Beat count n: IF = 4; MEM = 1, 2 or 4 from `mem_len_i`.
- Byte addresses are `addr+0 .. addr+n-1`, 32-bit wrap (0xFFFF_FFFF+1 = 0). Misaligned addresses are legal.
- Read sequence (cycles numbered after E0):
  - Cycles 1..n: drive `ram_a_o` = addr+k-1 in cycle k.
  - Cycles 2..n+1: capture `ram_din_i` into byte lane k-2.
  - Cycle n+2: DONE.
  - Unused upper lanes are 0.
- Write sequence:
  - Cycles 1..n: `ram_wr_o` = 1, `ram_a_o` = addr+k-1, `ram_dout_o` = `mem_wdata_i` byte k-1.
  - Cycle n+1: DONE.
- DONE lasts exactly one cycle:
  - The matching done pulse is asserted.
  - No new request is accepted in this cycle.
  - The FSM returns to IDLE, so the earliest next accept is at the end of the cycle after DONE.
- `jump_i` during IF_RD: FSM goes to IDLE at the next edge. No `if_done_o`, partial bytes are discarded, `if_inst_o` is unchanged.
- `jump_i` has no effect on MEM_RD/MEM_WR, or on an IF access that is already in DONE.
- Outside write beats: `ram_wr_o` = 0, `ram_a_o` = 0, `ram_dout_o` = 0.
- Requester dropping `req` before done (other than via `jump_i`): the transaction still completes and the pulse is ignored.

## Timing
- Reset values: state IDLE; `ram_a_o`, `ram_dout_o`, `ram_wr_o`, `if_done_o`, `mem_done_o` = 0; `if_inst_o`, `mem_rdata_o` = 0; beat counter 0.
- `rst` mid-transaction aborts at the next edge with no done pulse.
- Done-pulse latency from E0 (cycle number of the done pulse): word read 6, half read 4, byte read 3; word write 5, half write 3, byte write 2.
- Minimum spacing between accepts: latency + 1 cycles.
- All outputs are registered except `if_busy_o` and `mem_busy_o`.

## Structure
- Package `mem_ctrl_pkg`:
  - FSM state enum.
  - `LEN_B`/`LEN_H`/`LEN_W` codes.
  - `len_to_beats()` function returning a 3-bit beat count.
- Optional sub-module `mem_byte_buf`: 4-lane byte capture register with lane-select and clear, shared by IF and MEM reads.

## Test plan
- Reset, then IF fetch at 0x0000_0010 with RAM bytes 13,00,00,93 → `ram_a_o` 0x10..0x13 in cycles 1–4, `if_done_o` in cycle 6, `if_inst_o` = 0x9300_0013, `if_busy_o` = 1 in cycles 0–5.
- `mem_req_i` and `if_req_i` rise together; MEM word write of 0xDEAD_BEEF to 0x100 → `ram_wr_o` in cycles 1–4 with EF,BE,AD,DE; `mem_done_o` in cycle 5; IF accepted at the end of cycle 6.
- MEM half read at 0xFFFF_FFFF → addresses 0xFFFF_FFFF then 0x0000_0000; `mem_rdata_o` = 0x0000_xxyy, upper lanes 0; done in cycle 4.
- IF fetch with `jump_i` pulsed in cycle 3 → no `if_done_o`, FSM IDLE in cycle 4, `if_inst_o` unchanged; a new fetch accepted when `jump_i` = 0.
- `rst` asserted in cycle 2 of a MEM word write → `ram_wr_o` = 0 from the next cycle, no `mem_done_o`, all outputs at reset values.
- Byte read, then immediately another byte read with `req` held → second accept occurs only after the DONE cycle; two separate `mem_done_o` pulses 4 cycles apart.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the byte-serial RAM controller.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    IF_RD,
    MEM_RD,
    MEM_WR,
    DONE
  } state_t;

  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b10;

  // Length code 2'b11 is treated as a word access.
  function automatic logic [2:0] len_to_beats(input logic [1:0] len);
    case (len)
      LEN_B:   return 3'd1;
      LEN_H:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_buf.sv
// Four-lane byte capture register; merged shows the stored word with the selected lane replaced by din.
module mem_byte_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        we,
  input  logic [1:0]  lane,
  input  logic [7:0]  din,
  output logic [31:0] merged
);

  logic [31:0] data;

  always_comb begin
    merged = data;
    case (lane)
      2'd0:    merged[7:0]   = din;
      2'd1:    merged[15:8]  = din;
      2'd2:    merged[23:16] = din;
      default: merged[31:24] = din;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      data <= '0;
    end else if (we) begin
      data <= merged;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates the IF and MEM stages onto one 8-bit synchronous RAM port,
// serialising each access into little-endian byte beats.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_busy_o,
  output logic        if_done_o,
  output logic [31:0] if_inst_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [1:0]  mem_len_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic        mem_busy_o,
  output logic        mem_done_o,
  output logic [31:0] mem_rdata_o,
  input  logic [7:0]  ram_din_i,
  output logic [7:0]  ram_dout_o,
  output logic [31:0] ram_a_o,
  output logic        ram_wr_o
);

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  beats_q;
  logic [2:0]  beat;
  logic [2:0]  beat_nx;
  logic [31:0] next_a;
  logic [7:0]  wbyte;
  logic        rd_state;
  logic        buf_we;
  logic [1:0]  buf_lane;
  logic [31:0] buf_merged;

  assign if_busy_o  = if_req_i & ~if_done_o;
  assign mem_busy_o = mem_req_i & ~mem_done_o;

  assign beat_nx  = beat + 3'd1;
  assign next_a   = addr_q + {29'd0, beat_nx};
  assign rd_state = (state == IF_RD) || (state == MEM_RD);
  // RAM data lags the address by one cycle, so beat k captures lane k-1.
  assign buf_we   = rd_state && (beat != 3'd0);
  assign buf_lane = beat[1:0] - 2'd1;

  always_comb begin
    case (beat_nx[1:0])
      2'd0:    wbyte = wdata_q[7:0];
      2'd1:    wbyte = wdata_q[15:8];
      2'd2:    wbyte = wdata_q[23:16];
      default: wbyte = wdata_q[31:24];
    endcase
  end

  mem_byte_buf u_buf (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == IDLE),
    .we     (buf_we),
    .lane   (buf_lane),
    .din    (ram_din_i),
    .merged (buf_merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      beat        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      beats_q     <= '0;
      ram_a_o     <= '0;
      ram_dout_o  <= '0;
      ram_wr_o    <= 1'b0;
      if_done_o   <= 1'b0;
      mem_done_o  <= 1'b0;
      if_inst_o   <= '0;
      mem_rdata_o <= '0;
    end else begin
      if_done_o  <= 1'b0;
      mem_done_o <= 1'b0;
      case (state)
        IDLE: begin
          beat <= '0;
          if (mem_req_i) begin
            addr_q  <= mem_addr_i;
            wdata_q <= mem_wdata_i;
            beats_q <= len_to_beats(mem_len_i);
            ram_a_o <= mem_addr_i;
            if (mem_we_i) begin
              state      <= MEM_WR;
              ram_wr_o   <= 1'b1;
              ram_dout_o <= mem_wdata_i[7:0];
            end else begin
              state <= MEM_RD;
            end
          end else if (if_req_i && !jump_i) begin
            addr_q  <= if_addr_i;
            beats_q <= 3'd4;
            ram_a_o <= if_addr_i;
            state   <= IF_RD;
          end
        end
        IF_RD, MEM_RD: begin
          if (state == IF_RD && jump_i) begin
            state   <= IDLE;
            beat    <= '0;
            ram_a_o <= '0;
          end else if (beat == beats_q) begin
            state <= DONE;
            beat  <= '0;
            if (state == IF_RD) begin
              if_done_o <= 1'b1;
              if_inst_o <= buf_merged;
            end else begin
              mem_done_o  <= 1'b1;
              mem_rdata_o <= buf_merged;
            end
          end else begin
            beat    <= beat_nx;
            ram_a_o <= (beat_nx < beats_q) ? next_a : '0;
          end
        end
        MEM_WR: begin
          if (beat_nx < beats_q) begin
            beat       <= beat_nx;
            ram_a_o    <= next_a;
            ram_dout_o <= wbyte;
          end else begin
            state      <= DONE;
            beat       <= '0;
            ram_wr_o   <= 1'b0;
            ram_a_o    <= '0;
            ram_dout_o <= '0;
            mem_done_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: fixed cycle-by-cycle expectations against a small byte-RAM model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_busy_o;
  logic        if_done_o;
  logic [31:0] if_inst_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [1:0]  mem_len_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic        mem_busy_o;
  logic        mem_done_o;
  logic [31:0] mem_rdata_o;
  logic [7:0]  ram_din_i;
  logic [7:0]  ram_dout_o;
  logic [31:0] ram_a_o;
  logic        ram_wr_o;

  logic [7:0]  ram [0:1023];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  // Synchronous RAM: data for the address seen at an edge appears in the next cycle.
  always @(posedge clk) ram_din_i <= ram[ram_a_o[9:0]];

  mem_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .jump_i      (jump_i),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_busy_o   (if_busy_o),
    .if_done_o   (if_done_o),
    .if_inst_o   (if_inst_o),
    .mem_req_i   (mem_req_i),
    .mem_we_i    (mem_we_i),
    .mem_len_i   (mem_len_i),
    .mem_addr_i  (mem_addr_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_busy_o  (mem_busy_o),
    .mem_done_o  (mem_done_o),
    .mem_rdata_o (mem_rdata_o),
    .ram_din_i   (ram_din_i),
    .ram_dout_o  (ram_dout_o),
    .ram_a_o     (ram_a_o),
    .ram_wr_o    (ram_wr_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] exp_a;
  logic [7:0]  exp_b;

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[16] = 8'h13; ram[17] = 8'h00; ram[18] = 8'h00; ram[19] = 8'h93;
    ram[32] = 8'h11; ram[33] = 8'h22; ram[34] = 8'h33; ram[35] = 8'h44;
    ram[48] = 8'h0D; ram[49] = 8'hF0; ram[50] = 8'hFE; ram[51] = 8'hCA;
    ram[64] = 8'h77; ram[65] = 8'h88;
    ram[1023] = 8'hA5; ram[0] = 8'h5A;

    rst = 1'b1; jump_i = 1'b0; if_req_i = 1'b0; if_addr_i = '0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_len_i = 2'b00; mem_addr_i = '0; mem_wdata_i = '0;
    tick(); tick();

    // Reset state
    check("rst_ram_a", ram_a_o, 32'h0);
    check("rst_ram_wr", {31'd0, ram_wr_o}, 32'd0);
    check("rst_ram_dout", {24'd0, ram_dout_o}, 32'd0);
    check("rst_if_done", {31'd0, if_done_o}, 32'd0);
    check("rst_mem_done", {31'd0, mem_done_o}, 32'd0);
    check("rst_if_inst", if_inst_o, 32'h0);
    check("rst_mem_rdata", mem_rdata_o, 32'h0);
    rst = 1'b0;
    tick();

    // IF word fetch at 0x10
    if_req_i = 1'b1; if_addr_i = 32'h10;
    #1;
    for (int c = 0; c <= 6; c++) begin
      exp_a = (c >= 1 && c <= 4) ? 32'h10 + 32'(c - 1) : 32'h0;
      check("if1_ram_a", ram_a_o, exp_a);
      check("if1_done", {31'd0, if_done_o}, {31'd0, c == 6});
      check("if1_busy", {31'd0, if_busy_o}, {31'd0, c < 6});
      check("if1_wr", {31'd0, ram_wr_o}, 32'd0);
      if (c == 6) check("if1_inst", if_inst_o, 32'h9300_0013);
      if (c < 6) tick();
    end
    if_req_i = 1'b0;
    tick();

    // MEM word write and IF fetch requested together; MEM wins
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_len_i = 2'b10; mem_addr_i = 32'h100; mem_wdata_i = 32'hDEAD_BEEF;
    if_req_i = 1'b1; if_addr_i = 32'h20;
    #1;
    for (int c = 0; c <= 12; c++) begin
      if (c >= 1 && c <= 4) exp_a = 32'h100 + 32'(c - 1);
      else if (c >= 7 && c <= 10) exp_a = 32'h20 + 32'(c - 7);
      else exp_a = 32'h0;
      case (c)
        1: exp_b = 8'hEF;
        2: exp_b = 8'hBE;
        3: exp_b = 8'hAD;
        4: exp_b = 8'hDE;
        default: exp_b = 8'h00;
      endcase
      check("wr_ram_a", ram_a_o, exp_a);
      check("wr_ram_wr", {31'd0, ram_wr_o}, {31'd0, c >= 1 && c <= 4});
      check("wr_ram_dout", {24'd0, ram_dout_o}, {24'd0, exp_b});
      check("wr_mem_done", {31'd0, mem_done_o}, {31'd0, c == 5});
      check("wr_if_done", {31'd0, if_done_o}, {31'd0, c == 12});
      check("wr_if_busy", {31'd0, if_busy_o}, {31'd0, c < 12});
      if (c == 12) check("wr_if_inst", if_inst_o, 32'h4433_2211);
      if (c == 5) mem_req_i = 1'b0;
      if (c < 12) tick();
    end
    if_req_i = 1'b0; mem_we_i = 1'b0;
    tick();

    // MEM word read at 0x10
    mem_req_i = 1'b1; mem_len_i = 2'b10; mem_addr_i = 32'h10;
    #1;
    for (int c = 0; c <= 6; c++) begin
      exp_a = (c >= 1 && c <= 4) ? 32'h10 + 32'(c - 1) : 32'h0;
      check("rdw_ram_a", ram_a_o, exp_a);
      check("rdw_done", {31'd0, mem_done_o}, {31'd0, c == 6});
      check("rdw_busy", {31'd0, mem_busy_o}, {31'd0, c < 6});
      if (c == 6) check("rdw_rdata", mem_rdata_o, 32'h9300_0013);
      if (c < 6) tick();
    end
    mem_req_i = 1'b0;
    tick();

    // MEM half read wrapping from 0xFFFF_FFFF to 0
    mem_req_i = 1'b1; mem_len_i = 2'b01; mem_addr_i = 32'hFFFF_FFFF;
    #1;
    for (int c = 0; c <= 4; c++) begin
      exp_a = (c == 1) ? 32'hFFFF_FFFF : 32'h0;
      check("rdh_ram_a", ram_a_o, exp_a);
      check("rdh_done", {31'd0, mem_done_o}, {31'd0, c == 4});
      if (c == 4) check("rdh_rdata", mem_rdata_o, 32'h0000_5AA5);
      if (c < 4) tick();
    end
    mem_req_i = 1'b0;
    tick();

    // IF fetch aborted by jump in cycle 3; jump held in cycle 4 blocks re-accept
    if_req_i = 1'b1; if_addr_i = 32'h10;
    #1;
    for (int c = 0; c <= 11; c++) begin
      if (c >= 1 && c <= 3) exp_a = 32'h10 + 32'(c - 1);
      else if (c >= 6 && c <= 9) exp_a = 32'h30 + 32'(c - 6);
      else exp_a = 32'h0;
      check("jmp_ram_a", ram_a_o, exp_a);
      check("jmp_done", {31'd0, if_done_o}, {31'd0, c == 11});
      check("jmp_inst", if_inst_o, (c == 11) ? 32'hCAFE_F00D : 32'h4433_2211);
      if (c == 3) jump_i = 1'b1;
      if (c == 4) if_addr_i = 32'h30;
      if (c == 5) jump_i = 1'b0;
      if (c < 11) tick();
    end
    if_req_i = 1'b0;
    tick();

    // Reset asserted in cycle 2 of a MEM word write
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_len_i = 2'b10; mem_addr_i = 32'h200; mem_wdata_i = 32'h1122_3344;
    tick();
    check("rstw_c1_wr", {31'd0, ram_wr_o}, 32'd1);
    check("rstw_c1_dout", {24'd0, ram_dout_o}, 32'h44);
    tick();
    check("rstw_c2_a", ram_a_o, 32'h201);
    rst = 1'b1;
    tick();
    check("rstw_wr", {31'd0, ram_wr_o}, 32'd0);
    check("rstw_a", ram_a_o, 32'h0);
    check("rstw_dout", {24'd0, ram_dout_o}, 32'd0);
    check("rstw_mem_done", {31'd0, mem_done_o}, 32'd0);
    check("rstw_if_inst", if_inst_o, 32'h0);
    check("rstw_mem_rdata", mem_rdata_o, 32'h0);
    rst = 1'b0; mem_req_i = 1'b0; mem_we_i = 1'b0;
    tick();
    check("rstw_mem_done2", {31'd0, mem_done_o}, 32'd0);
    check("rstw_wr2", {31'd0, ram_wr_o}, 32'd0);

    // Back-to-back byte reads with req held
    mem_req_i = 1'b1; mem_len_i = 2'b00; mem_addr_i = 32'h40;
    #1;
    for (int c = 0; c <= 7; c++) begin
      if (c == 1) exp_a = 32'h40;
      else if (c == 5) exp_a = 32'h41;
      else exp_a = 32'h0;
      check("bb_ram_a", ram_a_o, exp_a);
      check("bb_done", {31'd0, mem_done_o}, {31'd0, c == 3 || c == 7});
      check("bb_busy", {31'd0, mem_busy_o}, {31'd0, c != 3 && c != 7});
      if (c == 3) check("bb_rdata1", mem_rdata_o, 32'h0000_0077);
      if (c == 7) check("bb_rdata2", mem_rdata_o, 32'h0000_0088);
      if (c == 3) mem_addr_i = 32'h41;
      if (c < 7) tick();
    end
    mem_req_i = 1'b0;
    tick();
    check("bb_idle_done", {31'd0, mem_done_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
